// File: rtl/dht11_pkg.sv
// Shared DHT11 definitions: responder FSM states, 100 MHz default timing,
// checksum and 40-bit frame packing used by both ends of the link.
package dht11_pkg;

   localparam int unsigned CNT_W = 26;

   localparam int unsigned DEF_START_MIN = 1000000;
   localparam int unsigned DEF_T_GO      = 3000;
   localparam int unsigned DEF_T_ACK_LO  = 8000;
   localparam int unsigned DEF_T_ACK_HI  = 8000;
   localparam int unsigned DEF_T_BIT_LO  = 5000;
   localparam int unsigned DEF_T_ZERO_HI = 2600;
   localparam int unsigned DEF_T_ONE_HI  = 7000;
   localparam int unsigned DEF_T_END_LO  = 5000;
   localparam int unsigned DEF_HOLDOFF   = 100000;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_HOST_LOW,
      ST_GO,
      ST_ACK_LO,
      ST_ACK_HI,
      ST_BIT_LO,
      ST_BIT_HI,
      ST_END_LO,
      ST_HOLDOFF
   } state_t;

   // Sum of the four payload bytes mod 256, optionally inverted to fake a bad frame.
   function automatic logic [7:0] dht11_checksum(input logic [7:0] hi, input logic [7:0] hf,
                                                 input logic [7:0] ti, input logic [7:0] tf,
                                                 input logic invert);
      logic [7:0] sum;
      sum = hi + hf + ti + tf;
      return invert ? ~sum : sum;
   endfunction

   // Wire order: hum_int, hum_float, tmp_int, tmp_float, checksum; MSB first.
   function automatic logic [39:0] dht11_pack(input logic [7:0] hi, input logic [7:0] hf,
                                              input logic [7:0] ti, input logic [7:0] tf,
                                              input logic [7:0] chk);
      return {hi, hf, ti, tf, chk};
   endfunction

endpackage

// File: rtl/dht11_line_sync.sv
// Two-flop synchronizer for the open-drain data line plus rising-edge detect.
module dht11_line_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic din_s,
   output logic rise
);

   logic meta;
   logic prev;

   // Resync the pin; reset to the idle (pulled-up) level so reset never looks like a start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta  <= 1'b1;
         din_s <= 1'b1;
         prev  <= 1'b1;
      end else begin
         meta  <= din;
         din_s <= meta;
         prev  <= din_s;
      end
   end

   assign rise = din_s & ~prev;

endmodule

// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: detects a host start pulse and answers with the
// acknowledge and a 40-bit frame built from the payload bytes.
module dht11_responder
   import dht11_pkg::*;
#(
   parameter int unsigned START_MIN = DEF_START_MIN,
   parameter int unsigned T_GO      = DEF_T_GO,
   parameter int unsigned T_ACK_LO  = DEF_T_ACK_LO,
   parameter int unsigned T_ACK_HI  = DEF_T_ACK_HI,
   parameter int unsigned T_BIT_LO  = DEF_T_BIT_LO,
   parameter int unsigned T_ZERO_HI = DEF_T_ZERO_HI,
   parameter int unsigned T_ONE_HI  = DEF_T_ONE_HI,
   parameter int unsigned T_END_LO  = DEF_T_END_LO,
   parameter int unsigned HOLDOFF   = DEF_HOLDOFF
) (
   input  logic       CLK,
   input  logic       RST,
   inout  logic       DHT_data,
   input  logic [7:0] hum_int,
   input  logic [7:0] hum_float,
   input  logic [7:0] tmp_int,
   input  logic [7:0] tmp_float,
   input  logic       parity_err,
   output logic       busy,
   output logic       frame_done
);

   localparam logic [CNT_W-1:0] START_LIM = CNT_W'(START_MIN);
   localparam logic [CNT_W-1:0] GO_LAST   = CNT_W'(T_GO - 1);
   localparam logic [CNT_W-1:0] ALO_LAST  = CNT_W'(T_ACK_LO - 1);
   localparam logic [CNT_W-1:0] AHI_LAST  = CNT_W'(T_ACK_HI - 1);
   localparam logic [CNT_W-1:0] BLO_LAST  = CNT_W'(T_BIT_LO - 1);
   localparam logic [CNT_W-1:0] ZERO_LAST = CNT_W'(T_ZERO_HI - 1);
   localparam logic [CNT_W-1:0] ONE_LAST  = CNT_W'(T_ONE_HI - 1);
   localparam logic [CNT_W-1:0] END_LAST  = CNT_W'(T_END_LO - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF - 1);

   state_t             state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [5:0]         bit_idx, idx_n;
   logic [39:0]        frame, frame_n;
   logic               done_n;
   logic               drive_low;
   logic               din_s;
   logic               rise;

   dht11_line_sync u_sync (
      .clk   (CLK),
      .rst_n (RST),
      .din   (DHT_data),
      .din_s (din_s),
      .rise  (rise)
   );

   assign DHT_data = drive_low ? 1'b0 : 1'bz;

   // State, timer, frame shift register and registered line/status outputs.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         frame      <= '0;
         drive_low  <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         bit_idx    <= idx_n;
         frame      <= frame_n;
         drive_low  <= (state_n == ST_ACK_LO) || (state_n == ST_BIT_LO) || (state_n == ST_END_LO);
         busy       <= (state_n != ST_IDLE) && (state_n != ST_HOST_LOW);
         frame_done <= done_n;
      end
   end

   // Next-state logic; each timed segment exits when the timer hits its last cycle.
   always_comb begin
      state_n = state;
      cnt_n   = cnt + 1'b1;
      idx_n   = bit_idx;
      frame_n = frame;
      done_n  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            cnt_n = '0;
            if (!din_s) state_n = ST_HOST_LOW;
         end
         ST_HOST_LOW: begin
            if (cnt == '1) cnt_n = cnt;
            if (rise) begin
               cnt_n = '0;
               if (cnt >= START_LIM) begin
                  frame_n = dht11_pack(hum_int, hum_float, tmp_int, tmp_float,
                                       dht11_checksum(hum_int, hum_float, tmp_int, tmp_float, parity_err));
                  idx_n   = '0;
                  // The detection cycle is the first GO cycle, so GO's timer starts at 1.
                  if (T_GO == 1) begin
                     state_n = ST_ACK_LO;
                  end else begin
                     state_n = ST_GO;
                     cnt_n   = CNT_W'(1);
                  end
               end else begin
                  state_n = ST_IDLE;
               end
            end
         end
         ST_GO: if (cnt == GO_LAST) begin
            state_n = ST_ACK_LO;
            cnt_n   = '0;
         end
         ST_ACK_LO: if (cnt == ALO_LAST) begin
            state_n = ST_ACK_HI;
            cnt_n   = '0;
         end
         ST_ACK_HI: if (cnt == AHI_LAST) begin
            state_n = ST_BIT_LO;
            cnt_n   = '0;
         end
         ST_BIT_LO: if (cnt == BLO_LAST) begin
            state_n = ST_BIT_HI;
            cnt_n   = '0;
         end
         ST_BIT_HI: if (cnt == (frame[39] ? ONE_LAST : ZERO_LAST)) begin
            cnt_n   = '0;
            frame_n = {frame[38:0], 1'b0};
            if (bit_idx == 6'd39) begin
               state_n = ST_END_LO;
            end else begin
               idx_n   = bit_idx + 6'd1;
               state_n = ST_BIT_LO;
            end
         end
         ST_END_LO: if (cnt == END_LAST) begin
            state_n = ST_HOLDOFF;
            cnt_n   = '0;
            done_n  = 1'b1;
         end
         ST_HOLDOFF: if (cnt == HOLD_LAST) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
         end
         default: begin
            state_n = ST_IDLE;
            cnt_n   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_dht11_responder.sv
// Directed bench for dht11_responder with scaled-down timing: records line
// segments, decodes the frame and checks timing, checksum and status outputs.
module tb_dht11_responder;

   localparam int START_MIN = 200;
   localparam int T_GO      = 30;
   localparam int T_ACK_LO  = 80;
   localparam int T_ACK_HI  = 80;
   localparam int T_BIT_LO  = 50;
   localparam int T_ZERO_HI = 26;
   localparam int T_ONE_HI  = 70;
   localparam int T_END_LO  = 50;
   localparam int HOLDOFF   = 1000;
   // 30+80+80+40*50+14*70+26*26+50 for a frame holding 14 ones
   localparam int FRAME_LEN = 3896;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       host_low = 1'b0;
   logic [7:0] hum_int = '0, hum_float = '0, tmp_int = '0, tmp_float = '0;
   logic       parity_err = 1'b0;
   logic       busy, frame_done;
   wire        dht_line;

   pullup (dht_line);
   assign dht_line = host_low ? 1'b0 : 1'bz;

   dht11_responder #(
      .START_MIN (START_MIN), .T_GO (T_GO), .T_ACK_LO (T_ACK_LO), .T_ACK_HI (T_ACK_HI),
      .T_BIT_LO (T_BIT_LO), .T_ZERO_HI (T_ZERO_HI), .T_ONE_HI (T_ONE_HI),
      .T_END_LO (T_END_LO), .HOLDOFF (HOLDOFF)
   ) dut (
      .CLK (clk), .RST (rst_n), .DHT_data (dht_line),
      .hum_int (hum_int), .hum_float (hum_float), .tmp_int (tmp_int), .tmp_float (tmp_float),
      .parity_err (parity_err), .busy (busy), .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic lvl;
      int   start;
      int   len;
   } seg_t;

   seg_t segs[$];
   logic prev_lvl = 1'b1;
   int   seg_start = 0;
   int   fd_count = 0;
   int   fd_cyc = -1;
   int   checks = 0;
   int   errors = 0;

   // Run-length record of the line and frame_done pulses, sampled mid-cycle.
   always @(negedge clk) begin
      seg_t s;
      if (dht_line !== prev_lvl) begin
         s.lvl = prev_lvl;
         s.start = seg_start;
         s.len = cyc - seg_start;
         segs.push_back(s);
         prev_lvl = dht_line;
         seg_start = cyc;
      end
      if (frame_done === 1'b1) begin
         fd_count++;
         fd_cyc = cyc;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
      #1;
   endtask

   // Host start pulse of low_cycles pin-low cycles; c0 is the detection cycle.
   task automatic start_pulse(input int low_cycles, output int c0);
      @(posedge clk); #1;
      host_low = 1'b1;
      repeat (low_cycles) @(posedge clk);
      #1;
      host_low = 1'b0;
      c0 = cyc + 2;
      @(negedge clk); #1;
      segs.delete();
      fd_count = 0;
      fd_cyc = -1;
   endtask

   task automatic check_frame(input string tag, input int c0, input logic [39:0] exp_bits);
      int bad;
      logic [39:0] got;
      seg_t lo, hi;
      bad = 0;
      got = '0;
      chk({tag, "_nseg"}, 64'(segs.size()), 64'd84);
      if (segs.size() == 84) begin
         if (segs[0].lvl !== 1'b1 || segs[0].len != T_GO + 2) bad++;
         if (segs[1].lvl !== 1'b0 || segs[1].len != T_ACK_LO) bad++;
         if (segs[2].lvl !== 1'b1 || segs[2].len != T_ACK_HI) bad++;
         for (int b = 0; b < 40; b++) begin
            lo = segs[3 + 2*b];
            hi = segs[4 + 2*b];
            if (lo.lvl !== 1'b0 || lo.len != T_BIT_LO) bad++;
            if (hi.lvl !== 1'b1) bad++;
            else if (hi.len == T_ONE_HI) got[39 - b] = 1'b1;
            else if (hi.len != T_ZERO_HI) bad++;
         end
         if (segs[83].lvl !== 1'b0 || segs[83].len != T_END_LO) bad++;
      end else begin
         bad = 1;
      end
      chk({tag, "_timing_bad"}, 64'(bad), 64'd0);
      chk({tag, "_bits"}, 64'(got), 64'(exp_bits));
      chk({tag, "_ones"}, 64'($countones(got)), 64'd14);
      chk({tag, "_fd_count"}, 64'(fd_count), 64'd1);
      chk({tag, "_fd_cycle"}, 64'(fd_cyc), 64'(c0 + FRAME_LEN));
      chk({tag, "_line_rel"}, 64'(dht_line), 64'd1);
   endtask

   initial begin
      int c0, bad;

      // Reset state
      repeat (5) @(posedge clk);
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(frame_done), 64'd0);
      chk("rst_line", 64'(dht_line), 64'd1);
      rst_n = 1'b1;
      hum_int = 8'h37; hum_float = 8'h00; tmp_int = 8'h19; tmp_float = 8'h05;
      parity_err = 1'b0;
      repeat (5) @(posedge clk);

      // Short host pulse: ignored entirely
      start_pulse(100, c0);
      bad = 0;
      repeat (400) begin
         @(negedge clk);
         if (dht_line !== 1'b1 || busy !== 1'b0) bad++;
      end
      chk("short_no_resp", 64'(bad), 64'd0);

      // Valid frame, checksum 0x55
      start_pulse(400, c0);
      wait_until(c0);
      chk("f1_busy_c0", 64'(busy), 64'd0);
      wait_until(c0 + 1);
      chk("f1_busy_c1", 64'(busy), 64'd1);
      wait_until(c0 + FRAME_LEN);
      check_frame("f1", c0, 40'h37_00_19_05_55);
      wait_until(c0 + FRAME_LEN + HOLDOFF - 1);
      chk("f1_busy_hold", 64'(busy), 64'd1);
      wait_until(c0 + FRAME_LEN + HOLDOFF);
      chk("f1_busy_end", 64'(busy), 64'd0);
      repeat (5) @(posedge clk);

      // Inverted checksum; mid-frame input change must not leak into the frame
      parity_err = 1'b1;
      start_pulse(400, c0);
      wait_until(c0 + 500);
      hum_int = 8'hFF; hum_float = 8'hFF; tmp_int = 8'hFF; tmp_float = 8'hFF;
      parity_err = 1'b0;
      wait_until(c0 + FRAME_LEN);
      check_frame("f2", c0, 40'h37_00_19_05_AA);
      hum_int = 8'h37; hum_float = 8'h00; tmp_int = 8'h19; tmp_float = 8'h05;
      wait_until(c0 + FRAME_LEN + HOLDOFF + 5);

      // Host activity during the frame and during holdoff is ignored
      start_pulse(400, c0);
      wait_until(c0 + 1000);
      host_low = 1'b1;
      wait_until(c0 + 1400);
      host_low = 1'b0;
      wait_until(c0 + FRAME_LEN);
      chk("f3_fd_count", 64'(fd_count), 64'd1);
      chk("f3_fd_cycle", 64'(fd_cyc), 64'(c0 + FRAME_LEN));
      wait_until(c0 + FRAME_LEN + 50);
      host_low = 1'b1;
      wait_until(c0 + FRAME_LEN + 450);
      host_low = 1'b0;
      wait_until(c0 + FRAME_LEN + HOLDOFF - 1);
      chk("f3_busy_hold", 64'(busy), 64'd1);
      wait_until(c0 + FRAME_LEN + HOLDOFF);
      chk("f3_busy_end", 64'(busy), 64'd0);
      bad = 0;
      repeat (300) begin
         @(negedge clk);
         if (dht_line !== 1'b1 || busy !== 1'b0) bad++;
      end
      chk("hold_pulse_ignored", 64'(bad), 64'd0);

      // Start after holdoff is answered
      start_pulse(400, c0);
      wait_until(c0 + FRAME_LEN);
      check_frame("f4", c0, 40'h37_00_19_05_55);
      wait_until(c0 + FRAME_LEN + HOLDOFF + 5);

      // Reset during bit 10 low (starts at c0+1170): line released at once
      start_pulse(400, c0);
      wait_until(c0 + 1180);
      chk("pre_rst_line", 64'(dht_line), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_line", 64'(dht_line), 64'd1);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (dht_line !== 1'b1 || busy !== 1'b0) bad++;
      end
      chk("post_rst_idle", 64'(bad), 64'd0);
      start_pulse(400, c0);
      wait_until(c0 + FRAME_LEN);
      check_frame("f5", c0, 40'h37_00_19_05_55);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
